universal_register: RTL and testbench
=====================================

Name: universal_register

Overview:
- Parametrised, multi-function successor to the plain 8-bit load register.
- Supports clear, parallel load, increment, decrement, and shift/rotate, with carry and zero flags and a tri-state bus driver.
- Single building block for the accumulator, B register, program counter and output register of the SAP-class datapath.
- All state changes occur on the rising clock edge.

Parameters:
WIDTH, 8, data width in bits (minimum 2).
RESET_VALUE, 0, value loaded into out_reg on asynchronous reset (WIDTH bits).

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear of out_reg and carry
load  input  1  parallel load from in_reg
in_reg  input  WIDTH  parallel load data
inc  input  1  increment by 1
dec  input  1  decrement by 1
shl  input  1  shift left one bit
shr  input  1  shift right one bit
rotate  input  1  0: shifts take serial_in; 1: shifts rotate
serial_in  input  1  bit shifted in when rotate=0
out_enable  input  1  drive bus_out
out_reg  output  WIDTH  registered contents
bus_out  output  WIDTH  out_reg when out_enable=1, else high-impedance
carry  output  1  registered carry/borrow/shifted-out bit
zero  output  1  combinational, 1 when out_reg == 0

Behaviour:
- Reset: asynchronous, active-low (reset=0) forces out_reg=RESET_VALUE and carry=0 immediately, with no clock edge required. Reset dominates every other input, including mid-operation; the register stays at RESET_VALUE while reset is low. The first operation executes on the first rising edge after reset goes high.
- Fixed priority per edge; exactly one operation executes: clear > load > inc > dec > shl > shr > hold. Lower-priority strobes asserted in the same cycle are ignored (e.g. inc+dec together performs inc only).
- clear: out_reg<=0, carry<=0.
- load: out_reg<=in_reg, carry<=0.
- inc: out_reg<=out_reg+1, modulo 2^WIDTH. carry<=1 only on wrap from all-ones to 0, else 0.
- dec: out_reg<=out_reg-1, modulo 2^WIDTH. carry<=1 only on borrow from 0 to all-ones, else 0.
- shl: out_reg<={out_reg[WIDTH-2:0], b}, with b=rotate?out_reg[WIDTH-1]:serial_in. carry<=out_reg[WIDTH-1].
- shr: out_reg<={b, out_reg[WIDTH-1:1]}, with b=rotate?out_reg[0]:serial_in. carry<=out_reg[0].
- hold: out_reg and carry unchanged.
- Latency: one clock from strobe to updated out_reg and carry. zero follows out_reg combinationally in the same cycle. bus_out follows out_enable combinationally with zero cycles of latency.
- rotate and serial_in are sampled only when a shift executes.
- in_reg is sampled only when load executes.

Optional Feature:
Macro UNIVERSAL_REGISTER_SHADOW_EN.
- Defined: adds ports save (input, 1), restore (input, 1) and shadow_out (output, WIDTH), plus an internal WIDTH-bit shadow register.
  - shadow resets to RESET_VALUE.
  - save: shadow<=out_reg at the edge. This is independent of the main operation, and the shadow captures the pre-edge value.
  - restore: out_reg<=shadow, carry<=0. Priority sits between load and inc: clear > load > restore > inc > ...
  - save and restore together: out_reg<=old shadow, shadow<=old out_reg (a swap).
- Undefined: none of these ports or the shadow register exist; priority is as listed in Behaviour.

Test Plan:
- Reset: assert reset=0 mid-cycle with out_reg=0x5A and carry=1 -> out_reg=0x00 and carry=0 immediately, without a clock edge; zero=1; bus_out=Z when out_enable=0.
- Load/priority: in_reg=0x3C with load=1, inc=1, dec=1 -> out_reg=0x3C, carry=0. Next cycle clear=1 with load=1 -> out_reg=0x00.
- Wrap: load 0xFF then inc -> 0x00, carry=1, zero=1. Then dec -> 0xFF, carry=1. Then dec -> 0xFE, carry=0.
- Shift/rotate: load 0x81. shl with rotate=1 -> 0x03, carry=1. shr with rotate=0, serial_in=1 -> 0x81, carry=1. shr with rotate=0, serial_in=0 -> 0x40, carry=1.
- Bus: out_reg=0xA5. Toggle out_enable 1/0 -> bus_out=0xA5 / all-Z in the same cycle; out_reg unaffected.
- Shadow (macro defined): load 0x11, save, load 0x22, then save+restore together -> out_reg=0x11, shadow_out=0x22. restore with load=1 and in_reg=0x33 -> out_reg=0x33.

Source files
------------

// File: rtl/universal_register.sv
// universal_register: clearable, loadable, counting, shifting register with carry/zero flags and tri-state bus driver
// Ports: clock, reset (async active-low); clear, load, in_reg, inc, dec, shl, shr, rotate, serial_in, out_enable;
//   out_reg, bus_out (Z when out_enable=0), carry (registered), zero (combinational).
// Optional macro UNIVERSAL_REGISTER_SHADOW_EN adds save, restore and shadow_out with a swap-capable shadow register.
// Priority per edge: clear > load > restore > inc > dec > shl > shr > hold.
module universal_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] in_reg,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic             out_enable,
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] shadow_out,
`endif
  output logic [WIDTH-1:0] out_reg,
  output logic [WIDTH-1:0] bus_out,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] shadow, next_reg;
  logic restore_sel, next_carry;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  assign restore_sel = restore;
  assign shadow_out = shadow;
  // shadow captures the pre-edge out_reg, so save+restore together swaps
  always_ff @(posedge clock or negedge reset)
    if (!reset) shadow <= RESET_VALUE;
    else if (save) shadow <= out_reg;
`else
  assign restore_sel = 1'b0;
  assign shadow = RESET_VALUE;
`endif
  always_comb begin
    next_reg = clear ? '0 : load ? in_reg : restore_sel ? shadow :
               inc ? out_reg + 1'b1 : dec ? out_reg - 1'b1 :
               shl ? {out_reg[WIDTH-2:0], rotate ? out_reg[WIDTH-1] : serial_in} :
               shr ? {rotate ? out_reg[0] : serial_in, out_reg[WIDTH-1:1]} : out_reg;
    next_carry = (clear || load || restore_sel) ? 1'b0 : inc ? &out_reg : dec ? ~|out_reg :
                 shl ? out_reg[WIDTH-1] : shr ? out_reg[0] : carry;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      out_reg <= RESET_VALUE;
      carry <= 1'b0;
    end else begin
      out_reg <= next_reg;
      carry <= next_carry;
    end
  assign zero = ~|out_reg;
  assign bus_out = out_enable ? out_reg : 'z;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: vector table, corner sequences and randomized model check of universal_register
module tb_universal_register;
  localparam int W = 8;
  localparam int M = 1 << W;
  logic clock = 0, reset = 0, clear = 0, load = 0, inc = 0, dec = 0, shl = 0, shr = 0;
  logic rotate = 0, serial_in = 0, out_enable = 0;
  logic [W-1:0] in_reg = '0;
  logic [W-1:0] out_reg;
  wire  [W-1:0] bus_out;
  logic carry, zero;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  logic save = 0, restore = 0;
  logic [W-1:0] shadow_out;
`endif
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  universal_register #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .in_reg(in_reg),
    .inc(inc), .dec(dec), .shl(shl), .shr(shr), .rotate(rotate), .serial_in(serial_in),
    .out_enable(out_enable),
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    .save(save), .restore(restore), .shadow_out(shadow_out),
`endif
    .out_reg(out_reg), .bus_out(bus_out), .carry(carry), .zero(zero));
  typedef struct {
    logic clr, ld, in, de, sl, sr, rot, sin;
    logic [W-1:0] din, eo;
    logic ec;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // a disabled bus must not present out_reg; accept Z (or 0 under 2-state simulation)
  task automatic chk_z(input string name);
    checks++;
    if (!(bus_out === {W{1'bz}} || bus_out === '0)) begin
      errors++;
      $display("FAIL %s got %h want Z", name, bus_out);
    end
  endtask
  task automatic drive(input logic clr, ld, i, d, sl, sr, rot, sin, input logic [W-1:0] din);
    {clear, load, inc, dec, shl, shr, rotate, serial_in} = {clr, ld, i, d, sl, sr, rot, sin};
    in_reg = din;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic vec_t mk(logic clr, ld, i, d, sl, sr, rot, sin, logic [W-1:0] din, eo, logic ec);
    vec_t v;
    v.clr = clr; v.ld = ld; v.in = i; v.de = d; v.sl = sl; v.sr = sr; v.rot = rot; v.sin = sin;
    v.din = din; v.eo = eo; v.ec = ec;
    return v;
  endfunction
  int mv, mc, ms;
  initial begin
    vecs.push_back(mk(0,1,1,1,0,0,0,0, 8'h3C, 8'h3C, 0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 8'h77, 8'h00, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 8'hFF, 8'hFF, 0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 8'h00, 8'h00, 1));
    vecs.push_back(mk(0,0,0,1,0,0,0,0, 8'h00, 8'hFF, 1));
    vecs.push_back(mk(0,0,0,1,0,0,0,0, 8'h00, 8'hFE, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 8'h81, 8'h81, 0));
    vecs.push_back(mk(0,0,0,0,1,0,1,0, 8'h00, 8'h03, 1));
    vecs.push_back(mk(0,0,0,0,0,1,0,1, 8'h00, 8'h81, 1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0, 8'h00, 8'h40, 1));
    vecs.push_back(mk(0,0,0,0,0,0,1,1, 8'h99, 8'h40, 1));
    vecs.push_back(mk(0,0,1,1,0,0,0,0, 8'h00, 8'h41, 0));
    vecs.push_back(mk(0,0,0,1,1,0,0,0, 8'h00, 8'h40, 0));
    vecs.push_back(mk(0,0,0,0,0,1,1,0, 8'h00, 8'h20, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0, 8'hAD, 8'hAD, 0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 8'h00, 8'h5A, 1));
    tick();
    tick();
    chk("reset_out", out_reg, 0);
    chk("reset_carry", carry, 0);
    chk("reset_zero", zero, 1);
    chk_z("reset_bus");
    @(negedge clock);
    reset = 1;
    foreach (vecs[k]) begin
      drive(vecs[k].clr, vecs[k].ld, vecs[k].in, vecs[k].de, vecs[k].sl, vecs[k].sr, vecs[k].rot, vecs[k].sin, vecs[k].din);
      tick();
      chk($sformatf("vec%0d_out", k), out_reg, vecs[k].eo);
      chk($sformatf("vec%0d_carry", k), carry, vecs[k].ec);
      chk($sformatf("vec%0d_zero", k), zero, vecs[k].eo == 0);
    end
    drive(0,1,0,0,0,0,0,0, 8'h42);
    @(negedge clock);
    reset = 0;
    #1;
    chk("async_reset_out", out_reg, 0);
    chk("async_reset_carry", carry, 0);
    chk("async_reset_zero", zero, 1);
    tick();
    chk("reset_dominates_load", out_reg, 0);
    @(negedge clock);
    reset = 1;
    drive(0,1,0,0,0,0,0,0, 8'hA5);
    tick();
    drive(0,0,0,0,0,0,0,0, 8'h00);
    out_enable = 1;
    #1;
    chk("bus_on", bus_out, 8'hA5);
    out_enable = 0;
    #1;
    chk_z("bus_off");
    chk("bus_reg_kept", out_reg, 8'hA5);
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    drive(0,1,0,0,0,0,0,0, 8'h11);
    tick();
    drive(0,0,0,0,0,0,0,0, 8'h00);
    save = 1;
    tick();
    save = 0;
    chk("shadow_save", shadow_out, 8'h11);
    drive(0,1,0,0,0,0,0,0, 8'h22);
    tick();
    drive(0,0,0,0,0,0,0,0, 8'h00);
    save = 1;
    restore = 1;
    tick();
    save = 0;
    chk("swap_out", out_reg, 8'h11);
    chk("swap_shadow", shadow_out, 8'h22);
    drive(0,1,0,0,0,0,0,0, 8'h33);
    tick();
    restore = 0;
    chk("load_over_restore", out_reg, 8'h33);
`endif
    drive(1,0,0,0,0,0,0,0, 8'h00);
    tick();
    mv = 0; mc = 0; ms = 0;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    ms = shadow_out;
`endif
    for (int n = 0; n < 600; n++) begin
      logic clr, ld, i, d, sl, sr, rot, sin, sv, rs, b;
      logic [W-1:0] din;
      int ov;
      clr = $urandom_range(0, 15) == 0; ld = $urandom_range(0, 5) == 0;
      i = $urandom_range(0, 3) == 0; d = $urandom_range(0, 3) == 0;
      sl = $urandom_range(0, 2) == 0; sr = $urandom_range(0, 2) == 0;
      rot = $urandom_range(0, 1) == 1; sin = $urandom_range(0, 1) == 1;
      din = W'($urandom);
      sv = $urandom_range(0, 4) == 0; rs = $urandom_range(0, 6) == 0;
`ifndef UNIVERSAL_REGISTER_SHADOW_EN
      sv = 0; rs = 0;
`else
      save = sv; restore = rs;
`endif
      drive(clr, ld, i, d, sl, sr, rot, sin, din);
      out_enable = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 40) == 0) begin
        reset = 0;
        #1;
        chk("rand_async_reset", out_reg, 0);
        mv = 0; mc = 0; ms = 0;
        #1;
        reset = 1;
        continue;
      end
      ov = mv;
      if (clr) begin mv = 0; mc = 0; end
      else if (ld) begin mv = din; mc = 0; end
      else if (rs) begin mv = ms; mc = 0; end
      else if (i) begin mc = (mv == M - 1); mv = (mv + 1) % M; end
      else if (d) begin mc = (mv == 0); mv = (mv + M - 1) % M; end
      else if (sl) begin mc = mv >= M / 2; b = rot ? mc[0] : sin; mv = (mv * 2) % M + b; end
      else if (sr) begin mc = mv % 2; b = rot ? mc[0] : sin; mv = mv / 2 + b * (M / 2); end
      if (sv) ms = ov;
      tick();
      chk("rand_out", out_reg, mv);
      chk("rand_carry", carry, mc);
      chk("rand_zero", zero, mv == 0);
      if (out_enable) chk("rand_bus", bus_out, mv);
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
      chk("rand_shadow", shadow_out, ms);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
